serial_subtractor: RTL and testbench

//   Bit-serial N-bit subtractor for the calculator datapath: computes a - b
//   LSB-first, one bit per clk, using a borrow chain instead of a carry chain.

---
 rtl/calc_pkg.sv | 19 +
 rtl/full_subtractor.sv | 19 +
 rtl/serial_subtractor.sv | 163 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: constants shared by the calculator datapath blocks.
// Holds the serial-unit FSM state encodings, the state width and the
// default operand width.
package calc_pkg;

   // Default operand / result width for the bit-serial arithmetic units
   localparam int DEFAULT_WIDTH = 8;

   // FSM state register width and encodings
   localparam int STATE_W = 2;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_SHIFT  = 2'd1;
   localparam state_t ST_NEGATE = 2'd2;
   localparam state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: combinational one-bit subtractor cell.
// Computes d = a - b - bi for a single bit position and the borrow
// that ripples into the next more significant position.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);

   logic w_axb;

   assign w_axb = a ^ b;
   assign d     = w_axb ^ bi;
   // Borrow when a=0,b=1, or when a==b and a borrow arrives from below
   assign bo    = (~a & b) | (~w_axb & bi);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor (a - b), LSB first,
// one bit per clock, using a single full_subtractor cell and a borrow
// register. The controller pulses start in IDLE and waits for finished.
//
// Optional feature macro: SERIAL_SUB_MAG_EN
//   defined   - sign-magnitude result: when the final borrow is 1 an extra
//               NEGATE pass two's-complements the result serially, so
//               diff = |a - b| and negative = borrow_out.
//   undefined - diff is the raw wrapped result and negative = diff[MSB].
module serial_subtractor
   import calc_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             finished,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             negative
);

   localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   // FSM and datapath registers
   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res;
   logic             r_borrow;
   logic [CNT_W-1:0] r_cnt;

   // Bit-cell outputs and the result register after one SHIFT step
   logic             w_d;
   logic             w_bo;
   logic [WIDTH-1:0] w_res_shift;

   full_subtractor u_cell (
      .a  (r_a_sh[0]),
      .b  (r_b_sh[0]),
      .bi (r_borrow),
      .d  (w_d),
      .bo (w_bo)
   );

   // New difference bit enters at the MSB so that after WIDTH steps the
   // first (LSB) bit has travelled down to bit 0
   assign w_res_shift = {w_d, r_res[WIDTH-1:1]};

`ifdef SERIAL_SUB_MAG_EN
   // Serial two's complement: copy bits up to and including the first 1,
   // invert every bit after it
   logic             r_seen_one;
   logic             w_neg_bit;
   logic [WIDTH-1:0] w_res_neg;

   assign w_neg_bit = r_seen_one ? ~r_res[0] : r_res[0];
   assign w_res_neg = {w_neg_bit, r_res[WIDTH-1:1]};
`else
   // The LSB of the result register is only consumed by the NEGATE pass
   logic w_unused_res_lsb;
   assign w_unused_res_lsb = r_res[0];
`endif

   // Control FSM, operand/result shift registers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_a_sh     <= '0;
         r_b_sh     <= '0;
         r_res      <= '0;
         r_borrow   <= 1'b0;
         r_cnt      <= '0;
         busy       <= 1'b0;
         finished   <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         negative   <= 1'b0;
`ifdef SERIAL_SUB_MAG_EN
         r_seen_one <= 1'b0;
`endif
      end else begin
         finished <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a_sh   <= a;
                  r_b_sh   <= b;
                  r_borrow <= 1'b0;
                  r_cnt    <= '0;
                  busy     <= 1'b1;
                  r_state  <= ST_SHIFT;
               end
            end

            ST_SHIFT: begin
               r_a_sh   <= r_a_sh >> 1;
               r_b_sh   <= r_b_sh >> 1;
               r_res    <= w_res_shift;
               r_borrow <= w_bo;
               if (r_cnt == CNT_LAST) begin
                  r_cnt <= '0;
`ifdef SERIAL_SUB_MAG_EN
                  if (w_bo) begin
                     // Negative result: convert to magnitude before DONE
                     r_seen_one <= 1'b0;
                     r_state    <= ST_NEGATE;
                  end else begin
                     r_state    <= ST_DONE;
                     finished   <= 1'b1;
                     diff       <= w_res_shift;
                     borrow_out <= 1'b0;
                     negative   <= 1'b0;
                  end
`else
                  r_state    <= ST_DONE;
                  finished   <= 1'b1;
                  diff       <= w_res_shift;
                  borrow_out <= w_bo;
                  negative   <= w_res_shift[WIDTH-1];
`endif
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

`ifdef SERIAL_SUB_MAG_EN
            ST_NEGATE: begin
               r_res      <= w_res_neg;
               r_seen_one <= r_seen_one | r_res[0];
               if (r_cnt == CNT_LAST) begin
                  r_cnt      <= '0;
                  r_state    <= ST_DONE;
                  finished   <= 1'b1;
                  diff       <= w_res_neg;
                  borrow_out <= r_borrow;
                  negative   <= r_borrow;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
`endif

            ST_DONE: begin
               // start is deliberately not sampled here
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: begin
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed-vector scoreboard bench for serial_subtractor
// (WIDTH=8). The driver pushes hand-computed expectations into a queue as each
// operation is accepted; an independent monitor pops and compares whenever
// finished is seen. Expectations follow SERIAL_SUB_MAG_EN when it is defined.
module tb_serial_subtractor;

   localparam int W = 8;
`ifdef SERIAL_SUB_MAG_EN
   localparam bit MAG = 1'b1;
`else
   localparam bit MAG = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] diff;
      logic         bo;
      logic         neg;
      int           fin_cyc;
   } exp_t;

   logic         clk   = 1'b0;
   logic         rst   = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         finished;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         negative;

   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb_q[$];

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .finished   (finished),
      .diff       (diff),
      .borrow_out (borrow_out),
      .negative   (negative)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expectation for one operation; base is the cycle seen at the negedge
   // right after the accepting edge
   task automatic push_exp(input logic [W-1:0] raw, input logic [W-1:0] mag,
                           input logic bo, input logic nraw, input int base);
      exp_t e;
      e.diff    = MAG ? mag : raw;
      e.bo      = bo;
      e.neg     = MAG ? bo : nraw;
      e.fin_cyc = base + ((MAG && bo) ? 2 * W : W);
      sb_q.push_back(e);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((busy !== 1'b0 || finished !== 1'b0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_idle: busy=%0b finished=%0b, want both 0 within 200 cycles", busy, finished);
      end
   endtask

   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] raw, input logic [W-1:0] mag,
                         input logic bo, input logic nraw);
      int k;
      wait_idle();
      a     = ia;
      b     = ib;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k     = cyc;
      push_exp(raw, mag, bo, nraw, k);
      chk("busy_after_accept", 32'(busy), 32'd1);
   endtask

   // Monitor: compare every finished pulse against the scoreboard
   initial begin
      exp_t         e;
      logic         prev_fin;
      logic [W-1:0] prev_diff;
      prev_fin  = 1'b0;
      prev_diff = '0;
      forever begin
         @(negedge clk);
         if (prev_fin) begin
            chk("finished_width", 32'(finished), 32'd0);
            chk("diff_hold", 32'(diff), 32'(prev_diff));
         end
         if (finished === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_finished: got finished=1, want no pending op (cycle %0d)", cyc);
            end else begin
               e = sb_q.pop_front();
               $display("[TB] txn cyc=%0d diff=0x%02h borrow=%0b neg=%0b (want 0x%02h %0b %0b @%0d)",
                        cyc, diff, borrow_out, negative, e.diff, e.bo, e.neg, e.fin_cyc);
               chk("diff", 32'(diff), 32'(e.diff));
               chk("borrow_out", 32'(borrow_out), 32'(e.bo));
               chk("negative", 32'(negative), 32'(e.neg));
               chk("latency", 32'(cyc), 32'(e.fin_cyc));
               chk("busy_in_done", 32'(busy), 32'd1);
            end
         end
         prev_fin  = (finished === 1'b1);
         prev_diff = diff;
      end
   end

   // Driver: directed vectors
   initial begin
      int k;
      int t;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_finished", 32'(finished), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_borrow", 32'(borrow_out), 32'd0);
      chk("rst_negative", 32'(negative), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      //      a      b      raw    mag    bo    nraw
      run_op(8'h35, 8'h12, 8'h23, 8'h23, 1'b0, 1'b0);
      run_op(8'h12, 8'h35, 8'hDD, 8'h23, 1'b1, 1'b1);
      run_op(8'h00, 8'h01, 8'hFF, 8'h01, 1'b1, 1'b1);
      run_op(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
      run_op(8'hF0, 8'h10, 8'hE0, 8'hE0, 1'b0, 1'b1);
      run_op(8'h64, 8'hC8, 8'h9C, 8'h64, 1'b1, 1'b1);
      run_op(8'h7F, 8'h80, 8'hFF, 8'h01, 1'b1, 1'b1);

      // start held high; operands change mid-op; second op accepted in the
      // IDLE cycle after DONE
      wait_idle();
      a     = 8'h35;
      b     = 8'h12;
      start = 1'b1;
      @(negedge clk);
      k = cyc;
      push_exp(8'h23, 8'h23, 1'b0, 1'b0, k);
      repeat (3) @(negedge clk);
      a = 8'h12;
      b = 8'h35;
      push_exp(8'hDD, 8'h23, 1'b1, 1'b1, k + W + 2);
      while (cyc < k + W + 2) @(negedge clk);
      chk("held_start_accept", 32'(busy), 32'd1);
      start = 1'b0;

      // Reset in SHIFT cycle 5 aborts the op; partial result discarded
      wait_idle();
      a     = 8'h12;
      b     = 8'h35;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_finished", 32'(finished), 32'd0);
      chk("abort_diff", 32'(diff), 32'd0);
      chk("abort_borrow", 32'(borrow_out), 32'd0);
      chk("abort_negative", 32'(negative), 32'd0);
      rst = 1'b0;
      run_op(8'h35, 8'h12, 8'h23, 8'h23, 1'b0, 1'b0);

      // Back-to-back operations
      run_op(8'h80, 8'h01, 8'h7F, 8'h7F, 1'b0, 1'b0);
      run_op(8'h01, 8'h80, 8'h81, 8'h7F, 1'b1, 1'b1);

      // Drain the scoreboard
      t = 0;
      while (sb_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      chk("sb_pending", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
